itype_instr_encoder: RTL

//  Write-side counterpart of the 17-bit immediate sign-extension path.

---
 rtl/itype_instr_encoder_pkg.sv | 31 +++
 rtl/itype_instr_encoder_imm_range_check.sv | 16 +
 rtl/itype_instr_encoder.sv | 116 +++++++++++
 3 files changed

// File: rtl/itype_instr_encoder_pkg.sv
// rtl/itype_instr_encoder_pkg.sv - I-type field layout, FSM states and word packing helper
package itype_instr_encoder_pkg;

    // Field widths and bit positions shared with the 17-bit sign-extension path
    localparam int OPCODE_W   = 5;
    localparam int RD_W       = 5;
    localparam int RS_W       = 5;
    localparam int IMM_W      = 17;
    localparam int OPCODE_LSB = 27;
    localparam int RD_LSB     = 22;
    localparam int RS_LSB     = 17;
    localparam int IMM_LSB    = 0;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACCEPT = 2'd1,
        S_EMIT   = 2'd2,
        S_FULL   = 2'd3
    } state_t;

    // {opcode, rd, rs, imm} in the order of the bit positions above
    function automatic logic [31:0] pack_word(
        input logic [OPCODE_W-1:0] op,
        input logic [RD_W-1:0]     rd,
        input logic [RS_W-1:0]     rs,
        input logic [IMM_W-1:0]    imm
    );
        return {op, rd, rs, imm};
    endfunction

endpackage

// File: rtl/itype_instr_encoder_imm_range_check.sv
// rtl/itype_instr_encoder_imm_range_check.sv - narrows a 32-bit value to a 17-bit immediate
module imm_range_check
    import itype_instr_encoder_pkg::*;
(
    input  logic [31:0]      value,
    output logic [IMM_W-1:0] imm,
    output logic             fits
);

    // Fits when the upper bits are all copies of bit 16, so sign-extending imm rebuilds value
    always_comb begin
        imm  = value[IMM_W-1:0];
        fits = (&value[31:IMM_W-1]) | ~(|value[31:IMM_W-1]);
    end

endmodule

// File: rtl/itype_instr_encoder.sv
// rtl/itype_instr_encoder.sv - packs I-type fields and writes them to consecutive imem addresses
module itype_instr_encoder
    import itype_instr_encoder_pkg::*;
#(
    parameter int ADDR_W = 12,
    parameter int ERR_W  = 8
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                start,
    input  logic                stop,
    input  logic [ADDR_W-1:0]   base_addr,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [OPCODE_W-1:0] in_opcode,
    input  logic [RD_W-1:0]     in_rd,
    input  logic [RS_W-1:0]     in_rs,
    input  logic [31:0]         in_value,
    output logic [ADDR_W-1:0]   imem_addr,
    output logic [31:0]         imem_data,
    output logic                imem_wren,
    output logic                range_err,
    output logic [ERR_W-1:0]    err_count,
    output logic [ADDR_W:0]     word_count,
    output logic                busy,
    output logic                full
);

    state_t           state;
    state_t           state_nxt;
    logic [IMM_W-1:0] imm;
    logic             fits;
    logic [31:0]      cap_word;
    logic             cap_fits;
    logic [31:0]      data_hold;
    logic             capture;

    imm_range_check u_range (
        .value (in_value),
        .imm   (imm),
        .fits  (fits)
    );

    // Strobes come straight from EMIT so a start in that cycle can still suppress them
    always_comb begin
        in_ready  = (state == S_ACCEPT);
        busy      = (state != S_IDLE);
        full      = (state == S_FULL);
        imem_wren = (state == S_EMIT) && cap_fits && !start;
        range_err = (state == S_EMIT) && !cap_fits && !start;
        imem_data = imem_wren ? cap_word : data_hold;
        capture   = (state == S_ACCEPT) && in_valid && !start && !stop;
    end

    // State register
    always_ff @(posedge clock or posedge reset) begin
        if (reset) state <= S_IDLE;
        else       state <= state_nxt;
    end

    // Next state: start overrides everything; stop in EMIT takes effect after the strobe
    always_comb begin
        state_nxt = state;
        if (start) begin
            state_nxt = S_ACCEPT;
        end else begin
            case (state)
                S_IDLE:   state_nxt = S_IDLE;
                S_ACCEPT: begin
                    if (stop)          state_nxt = S_IDLE;
                    else if (in_valid) state_nxt = S_EMIT;
                end
                S_EMIT: begin
                    if (cap_fits && (imem_addr == '1)) state_nxt = S_FULL;
                    else if (stop)                     state_nxt = S_IDLE;
                    else                               state_nxt = S_ACCEPT;
                end
                S_FULL: begin
                    if (stop) state_nxt = S_IDLE;
                end
                default:  state_nxt = S_IDLE;
            endcase
        end
    end

    // Captured fields, write address, held data and counters
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            cap_word   <= '0;
            cap_fits   <= 1'b0;
            data_hold  <= '0;
            imem_addr  <= '0;
            word_count <= '0;
            err_count  <= '0;
        end else if (start) begin
            cap_fits   <= 1'b0;
            imem_addr  <= base_addr;
            word_count <= '0;
            err_count  <= '0;
        end else begin
            if (capture) begin
                cap_word <= pack_word(in_opcode, in_rd, in_rs, imm);
                cap_fits <= fits;
            end
            if (imem_wren) begin
                data_hold  <= cap_word;
                imem_addr  <= imem_addr + ADDR_W'(1);
                word_count <= word_count + (ADDR_W + 1)'(1);
            end
            if (range_err && (err_count != '1)) begin
                err_count <= err_count + ERR_W'(1);
            end
        end
    end

endmodule
